// File: rtl/div_iter.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per clock,
// quotient to LO (q), remainder to HI (r), with divide-by-zero flag.
module div_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dbz
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state;
  logic             sign_a;
  logic             sign_b;
  logic             zero_div;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] a_raw;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  // Operand magnitudes and one trial subtraction; diff MSB set means borrow.
  always_comb begin
    mag_a  = (is_signed && a[WIDTH-1]) ? (-a) : a;
    mag_b  = (is_signed && b[WIDTH-1]) ? (-b) : b;
    rem_sh = {rem, quo[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvsr};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      q        <= '0;
      r        <= '0;
      dbz      <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      zero_div <= 1'b0;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      a_raw    <= '0;
      count    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign_a   <= a[WIDTH-1] & is_signed;
            sign_b   <= b[WIDTH-1] & is_signed;
            quo      <= mag_a;
            dvsr     <= mag_b;
            a_raw    <= a;
            zero_div <= (b == '0);
            rem      <= '0;
            count    <= '0;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          // Restore on borrow: keep the shifted remainder, quotient bit 0.
          quo   <= {quo[WIDTH-2:0], ~diff[WIDTH]};
          rem   <= diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (zero_div) begin
            q   <= '1;
            r   <= a_raw;
            dbz <= 1'b1;
          end else begin
            q   <= (sign_a ^ sign_b) ? (-quo) : quo;
            r   <= sign_a ? (-rem) : rem;
            dbz <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter: arithmetic, corner cases,
// divide-by-zero, start handshake and mid-operation reset.
module tb_div_iter;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic [31:0] r;
  logic        dbz;

  int checks;
  int errors;

  div_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .q(q), .r(r), .dbz(dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for done, counting edges from the current point; bounded.
  task automatic wait_done(output int n, output bit timeout);
    n = 0;
    timeout = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      n++;
      if (done) begin
        timeout = 1'b0;
        return;
      end
    end
  endtask

  // Issue one start pulse and wait for completion.
  task automatic do_op(input bit sgn, input logic [31:0] va, input logic [31:0] vb,
                       output int n, output bit timeout);
    start = 1'b1; is_signed = sgn; a = va; b = vb;
    tick();
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678; is_signed = ~sgn;
    wait_done(n, timeout);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (q !== 32'h0) begin errors++; $display("FAIL reset_q got=%h exp=0", q); end
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_r got=%h exp=0", r); end
    checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b exp=0", dbz); end
  endtask

  task automatic test_unsigned();
    int n; bit to;
    start = 1'b1; is_signed = 1'b0; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL udiv_busy_after_start got=%b exp=1", busy); end
    wait_done(n, to);
    checks++; if (to || n != 33) begin errors++; $display("FAIL udiv_latency got=%0d timeout=%0b exp=33", n, to); end
    checks++; if (q !== 32'd14) begin errors++; $display("FAIL udiv_q got=%h exp=%h", q, 32'd14); end
    checks++; if (r !== 32'd2) begin errors++; $display("FAIL udiv_r got=%h exp=%h", r, 32'd2); end
    checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL udiv_dbz got=%b exp=0", dbz); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL udiv_busy_at_done got=%b exp=0", busy); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL udiv_done_pulse got=%b exp=0", done); end
    checks++; if (q !== 32'd14) begin errors++; $display("FAIL udiv_q_hold got=%h exp=%h", q, 32'd14); end
  endtask

  task automatic test_signed();
    int n; bit to;
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, n, to);
    checks++; if (to || n != 33) begin errors++; $display("FAIL sdiv1_latency got=%0d timeout=%0b exp=33", n, to); end
    checks++; if (q !== 32'hFFFF_FFFD) begin errors++; $display("FAIL sdiv1_q got=%h exp=fffffffd", q); end
    checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sdiv1_r got=%h exp=ffffffff", r); end
    tick();
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE, n, to);
    checks++; if (q !== 32'hFFFF_FFFD) begin errors++; $display("FAIL sdiv2_q got=%h exp=fffffffd", q); end
    checks++; if (r !== 32'd1) begin errors++; $display("FAIL sdiv2_r got=%h exp=00000001", r); end
    tick();
  endtask

  task automatic test_corner();
    int n; bit to;
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, n, to);
    checks++; if (q !== 32'h8000_0000) begin errors++; $display("FAIL ovf_q got=%h exp=80000000", q); end
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL ovf_r got=%h exp=00000000", r); end
    checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL ovf_dbz got=%b exp=0", dbz); end
    tick();
    do_op(1'b0, 32'hFFFF_FFFF, 32'd1, n, to);
    checks++; if (q !== 32'hFFFF_FFFF) begin errors++; $display("FAIL umax_q got=%h exp=ffffffff", q); end
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL umax_r got=%h exp=00000000", r); end
    tick();
    do_op(1'b0, 32'hFFFF_FFF9, 32'd2, n, to);
    checks++; if (q !== 32'h7FFF_FFFC) begin errors++; $display("FAIL ubig_q got=%h exp=7ffffffc", q); end
    checks++; if (r !== 32'd1) begin errors++; $display("FAIL ubig_r got=%h exp=00000001", r); end
    tick();
  endtask

  task automatic test_div_by_zero();
    int n; bit to;
    do_op(1'b1, 32'd5, 32'd0, n, to);
    checks++; if (to || n != 33) begin errors++; $display("FAIL sdbz_latency got=%0d timeout=%0b exp=33", n, to); end
    checks++; if (q !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sdbz_q got=%h exp=ffffffff", q); end
    checks++; if (r !== 32'd5) begin errors++; $display("FAIL sdbz_r got=%h exp=00000005", r); end
    checks++; if (dbz !== 1'b1) begin errors++; $display("FAIL sdbz_dbz got=%b exp=1", dbz); end
    tick();
    do_op(1'b0, 32'd5, 32'd0, n, to);
    checks++; if (to || n != 33) begin errors++; $display("FAIL udbz_latency got=%0d timeout=%0b exp=33", n, to); end
    checks++; if (q !== 32'hFFFF_FFFF) begin errors++; $display("FAIL udbz_q got=%h exp=ffffffff", q); end
    checks++; if (r !== 32'd5) begin errors++; $display("FAIL udbz_r got=%h exp=00000005", r); end
    checks++; if (dbz !== 1'b1) begin errors++; $display("FAIL udbz_dbz got=%b exp=1", dbz); end
    tick();
    do_op(1'b1, 32'hFFFF_FFFB, 32'd0, n, to);
    checks++; if (r !== 32'hFFFF_FFFB) begin errors++; $display("FAIL ndbz_r got=%h exp=fffffffb", r); end
    tick();
  endtask

  task automatic test_start_while_busy();
    int n; bit to; bit seen;
    start = 1'b1; is_signed = 1'b0; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0;
    repeat (9) tick();
    start = 1'b1; a = 32'd9; b = 32'd3;
    tick();
    start = 1'b0;
    wait_done(n, to);
    checks++; if (to || n != 23) begin errors++; $display("FAIL busy_start_latency got=%0d timeout=%0b exp=23", n, to); end
    checks++; if (q !== 32'd14) begin errors++; $display("FAIL busy_start_q got=%h exp=%h", q, 32'd14); end
    checks++; if (r !== 32'd2) begin errors++; $display("FAIL busy_start_r got=%h exp=%h", r, 32'd2); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL busy_start_dropped got=%b exp=0", seen); end
  endtask

  task automatic test_back_to_back();
    int n; bit to;
    do_op(1'b0, 32'd100, 32'd7, n, to);
    start = 1'b1; is_signed = 1'b0; a = 32'd9; b = 32'd3;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_accept got busy=%b done=%b exp busy=1 done=0", busy, done); end
    wait_done(n, to);
    checks++; if (to || n != 33) begin errors++; $display("FAIL b2b_latency got=%0d timeout=%0b exp=33", n, to); end
    checks++; if (q !== 32'd3) begin errors++; $display("FAIL b2b_q got=%h exp=%h", q, 32'd3); end
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL b2b_r got=%h exp=%h", r, 32'd0); end
    tick();
  endtask

  task automatic test_reset_mid();
    int n; bit to; bit seen;
    start = 1'b1; is_signed = 1'b0; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0;
    repeat (14) tick();
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got busy=%b done=%b exp 0 0", busy, done); end
    checks++; if (q !== 32'h0 || r !== 32'h0) begin errors++; $display("FAIL midrst_qr got q=%h r=%h exp 0 0", q, r); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_done got=%b exp=0", seen); end
    do_op(1'b0, 32'd100, 32'd7, n, to);
    checks++; if (to || n != 33) begin errors++; $display("FAIL midrst_fresh_latency got=%0d timeout=%0b exp=33", n, to); end
    checks++; if (q !== 32'd14 || r !== 32'd2) begin errors++; $display("FAIL midrst_fresh_qr got q=%h r=%h exp 0000000e 00000002", q, r); end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_corner();
    test_div_by_zero();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
